fnd_controller: RTL and testbench

Drives a 4-digit common-anode 7-segment display (FND) from the stopwatch/watch time outputs (msec, sec, min, hour). It sits directly downstream of the stopwatch datapath. It time-multiplexes the four digits at a programmable scan rate and selects between a sec:msec view and an hour:min view. It also blinks the centre decimal point as a half-second indicator.

---
 rtl/fnd_controller.sv | 126 ++++++++++++
 tb/tb_fnd_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_controller.sv
// fnd_controller: scans a 4-digit common-anode 7-segment display showing either
// sec:msec or hour:min, with the centre decimal point as a half-second blinker.
module fnd_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sel_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_tick;
    digit_t           digit_sel;
    digit_t           digit_next;
    logic [3:0]       code;
    logic [3:0]       com_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign scan_tick = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    // Scan divider: free-running 0..SCAN_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Digit-select state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel <= DIG0;
        end else begin
            digit_sel <= digit_next;
        end
    end

    // Next digit: advance once per scan tick, wrapping 3 -> 0
    always_comb begin
        digit_next = digit_sel;
        if (scan_tick) begin
            case (digit_sel)
                DIG0:    digit_next = DIG1;
                DIG1:    digit_next = DIG2;
                DIG2:    digit_next = DIG3;
                default: digit_next = DIG0;
            endcase
        end
    end

    // Digit value and enable for the currently selected position
    always_comb begin
        code     = '0;
        com_next = '1;
        case (digit_sel)
            DIG0: begin
                code     = i_sel_mode ? 4'(min % 6'd10) : 4'(msec % 7'd10);
                com_next = 4'b1110;
            end
            DIG1: begin
                code     = i_sel_mode ? 4'(min / 6'd10) : 4'(msec / 7'd10);
                com_next = 4'b1101;
            end
            DIG2: begin
                code     = i_sel_mode ? 4'(hour % 5'd10) : 4'(sec % 6'd10);
                com_next = 4'b1011;
            end
            default: begin
                code     = i_sel_mode ? 4'(hour / 5'd10) : 4'(sec / 6'd10);
                com_next = 4'b0111;
            end
        endcase
        dp_next = !((digit_sel == DIG2) && (msec < 7'd50));
    end

    // Segment decode (active-low g..a); codes above 9 blank the digit
    always_comb begin
        seg_next = 7'h7F;
        case (code)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h7F;
        endcase
    end

    // Output registers: one cycle behind digit select and inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= '1;
            fnd_data <= '1;
        end else begin
            fnd_com  <= com_next;
            fnd_data <= {dp_next, seg_next};
        end
    end

endmodule

// File: tb/tb_fnd_controller.sv
// tb_fnd_controller: directed scenarios plus randomized inputs/resets, checked
// every cycle against a cycle-count based model of the scanned display.
module tb_fnd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_sel_mode = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    fnd_controller #(
        .CLK_FREQ(1000),
        .SCAN_HZ (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sel_mode(i_sel_mode),
        .msec      (msec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data)
    );

    always #5 clk = ~clk;

    // Reference tables: full active-low patterns with dp off, and digit enables
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] com_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [7:0] model_data(int d, bit mode, int ms, int s, int mi, int h);
        int v;
        logic [7:0] r;
        case (d)
            0:       v = mode ? mi % 10 : ms % 10;
            1:       v = mode ? mi / 10 : ms / 10;
            2:       v = mode ? h % 10  : s % 10;
            default: v = mode ? h / 10  : s / 10;
        endcase
        r = (v <= 9) ? seg_tab[v] : 8'hFF;
        if (d == 2 && ms < 50) r[7] = 1'b0;
        return r;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Model: edges since reset release determine which digit is shown
    int         edges = 0;
    logic [3:0] exp_com = 4'b1111;
    logic [7:0] exp_data = 8'hFF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges    <= 0;
            exp_com  <= 4'b1111;
            exp_data <= 8'hFF;
        end else begin
            exp_com  <= com_tab[(edges / 10) % 4];
            exp_data <= model_data((edges / 10) % 4, i_sel_mode, int'(msec), int'(sec),
                                   int'(min), int'(hour));
            edges    <= edges + 1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("model_com", {4'b0, fnd_com}, {4'b0, exp_com});
        check("model_data", fnd_data, exp_data);
    end

    // Release reset at a falling edge; subsequent posedges are edge 1, 2, ...
    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic edges_then_settle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_com", {4'b0, fnd_com}, 8'h0F);
        check("reset_data", fnd_data, 8'hFF);

        // Mode 0 scan: msec=37, sec=42
        i_sel_mode = 1'b0; msec = 7'd37; sec = 6'd42; min = 6'd5; hour = 5'd23;
        restart();
        edges_then_settle(1);
        check("m0_d0_com", {4'b0, fnd_com}, 8'h0E);
        check("m0_d0", fnd_data, 8'hF8);
        edges_then_settle(9);
        check("m0_d0_hold", fnd_data, 8'hF8);
        edges_then_settle(1);
        check("m0_d1_com", {4'b0, fnd_com}, 8'h0D);
        check("m0_d1", fnd_data, 8'hB0);
        edges_then_settle(10);
        check("m0_d2_com", {4'b0, fnd_com}, 8'h0B);
        check("m0_d2", fnd_data, 8'h24);
        edges_then_settle(10);
        check("m0_d3_com", {4'b0, fnd_com}, 8'h07);
        check("m0_d3", fnd_data, 8'h99);
        edges_then_settle(10);
        check("m0_wrap_com", {4'b0, fnd_com}, 8'h0E);

        // Mid-scan reset at digit 2 (edge 61 onward shows digit 2)
        edges_then_settle(22);
        check("pre_rst_com", {4'b0, fnd_com}, 8'h0B);
        rst = 1'b1;
        #1;
        check("async_rst_com", {4'b0, fnd_com}, 8'h0F);
        check("async_rst_data", fnd_data, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        edges_then_settle(1);
        check("post_rst_com", {4'b0, fnd_com}, 8'h0E);
        edges_then_settle(9);
        check("post_rst_hold", {4'b0, fnd_com}, 8'h0E);
        edges_then_settle(1);
        check("post_rst_d1", {4'b0, fnd_com}, 8'h0D);

        // Mode 1 scan: hour=23, min=05, msec=75
        i_sel_mode = 1'b1; msec = 7'd75;
        restart();
        edges_then_settle(1);
        check("m1_d0", fnd_data, 8'h92);
        edges_then_settle(10);
        check("m1_d1", fnd_data, 8'hC0);
        edges_then_settle(10);
        check("m1_d2", fnd_data, 8'hB0);
        edges_then_settle(10);
        check("m1_d3", fnd_data, 8'hA4);

        // Dot boundary on digit 2
        i_sel_mode = 1'b0; msec = 7'd10; sec = 6'd42;
        restart();
        edges_then_settle(21);
        @(negedge clk); msec = 7'd49;
        edges_then_settle(1);
        check("dot_49", {7'b0, fnd_data[7]}, 8'h00);
        @(negedge clk); msec = 7'd50;
        #1;
        check("dot_50_before", {7'b0, fnd_data[7]}, 8'h00);
        edges_then_settle(1);
        check("dot_50", {7'b0, fnd_data[7]}, 8'h01);
        @(negedge clk); msec = 7'd0;
        edges_then_settle(1);
        check("dot_0", fnd_data, 8'h24);

        // Out-of-range msec
        msec = 7'd120;
        restart();
        edges_then_settle(1);
        check("oor_d0", fnd_data, 8'hC0);
        edges_then_settle(10);
        check("oor_d1", fnd_data, 8'hFF);

        // Mode switch while digit 3 is active
        msec = 7'd75; sec = 6'd42; hour = 5'd23; i_sel_mode = 1'b0;
        restart();
        edges_then_settle(31);
        check("sw_before", fnd_data, 8'h99);
        @(negedge clk); i_sel_mode = 1'b1;
        edges_then_settle(1);
        check("sw_after", fnd_data, 8'hA4);
        check("sw_com", {4'b0, fnd_com}, 8'h07);
        edges_then_settle(8);
        check("sw_com_hold", {4'b0, fnd_com}, 8'h07);
        edges_then_settle(1);
        check("sw_frame_wrap", {4'b0, fnd_com}, 8'h0E);

        // Randomized inputs with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                i_sel_mode = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    msec = 7'($urandom);
                    sec  = 6'($urandom);
                    min  = 6'($urandom);
                    hour = 5'($urandom);
                end else begin
                    msec = 7'($urandom_range(0, 99));
                    sec  = 6'($urandom_range(0, 59));
                    min  = 6'($urandom_range(0, 59));
                    hour = 5'($urandom_range(0, 23));
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 3));
                rst = 1'b1;
                #1;
                check("rand_rst_com", {4'b0, fnd_com}, 8'h0F);
                check("rand_rst_data", fnd_data, 8'hFF);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
